// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bundle: PC register, instruction memory handshake and status.
// The instr_count_o signal exists only when PC_FETCH_INSTR_COUNT_EN is defined.
interface pc_fetch_ctrl_if;
    logic [15:0] pc_cur;
    logic        imem_ready_i;
    logic        halt_i;
    logic        br_taken_i;
    logic [15:0] br_target_i;
    logic [15:0] pc_next_o;
    logic        freeze_o;
    logic        imem_req_o;
    logic        halted_o;
    logic [1:0]  state_o;
`ifdef PC_FETCH_INSTR_COUNT_EN
    logic [15:0] instr_count_o;

    modport slave (
        input  pc_cur, imem_ready_i, halt_i, br_taken_i, br_target_i,
        output pc_next_o, freeze_o, imem_req_o, halted_o, state_o, instr_count_o
    );

    modport master (
        output pc_cur, imem_ready_i, halt_i, br_taken_i, br_target_i,
        input  pc_next_o, freeze_o, imem_req_o, halted_o, state_o, instr_count_o
    );
`else
    modport slave (
        input  pc_cur, imem_ready_i, halt_i, br_taken_i, br_target_i,
        output pc_next_o, freeze_o, imem_req_o, halted_o, state_o
    );

    modport master (
        output pc_cur, imem_ready_i, halt_i, br_taken_i, br_target_i,
        input  pc_next_o, freeze_o, imem_req_o, halted_o, state_o
    );
`endif
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC sequencing FSM: boot vector, fetch/wait handshake, branch redirect and sticky halt.
// Optional retired-instruction counter enabled by defining PC_FETCH_INSTR_COUNT_EN.
module pc_fetch_ctrl #(
    parameter logic [15:0] RESET_VEC = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_ctrl_if.slave  bus
);

    localparam logic [1:0] StBoot  = 2'b00;
    localparam logic [1:0] StFetch = 2'b01;
    localparam logic [1:0] StWait  = 2'b10;
    localparam logic [1:0] StHalt  = 2'b11;

    logic [1:0]  state_q, state_d;
    logic        halted_q;
    logic        accept;
    logic [15:0] pc_next;
    logic        freeze;
    logic        imem_req;

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        pc_next  = bus.pc_cur;
        freeze   = 1'b1;
        imem_req = 1'b0;
        case (state_q)
            StBoot: begin
                pc_next = RESET_VEC;
                freeze  = 1'b0;
                state_d = StFetch;
            end
            StFetch, StWait: begin
                imem_req = 1'b1;
                if (bus.imem_ready_i) begin
                    accept = 1'b1;
                    if (bus.halt_i) begin
                        state_d = StHalt;
                    end else begin
                        freeze  = 1'b0;
                        state_d = StFetch;
                        // Branch targets are forced to halfword alignment.
                        pc_next = bus.br_taken_i ? {bus.br_target_i[15:1], 1'b0}
                                                 : bus.pc_cur + 16'd2;
                    end
                end else begin
                    state_d = StWait;
                end
            end
            default: begin
                state_d = StHalt;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StBoot;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == StHalt);
        end
    end

    assign bus.pc_next_o  = pc_next;
    assign bus.freeze_o   = freeze;
    assign bus.imem_req_o = imem_req;
    assign bus.halted_o   = halted_q;
    assign bus.state_o    = state_q;

`ifdef PC_FETCH_INSTR_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 16'h0000;
        end else if (accept && !bus.halt_i && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign bus.instr_count_o = count_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: vector table, directed sequences, random vs model.
module tb_pc_fetch_ctrl;

    localparam logic [15:0] ResetVec = 16'h0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pc_fetch_ctrl_if bus ();

    pc_fetch_ctrl #(.RESET_VEC(ResetVec)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // PC register in the loop, or pc_cur driven directly for table vectors.
    logic        loop_en = 1'b1;
    logic [15:0] pc_drv  = 16'h0000;
    logic [15:0] pc_reg;
    always @(posedge clk) if (!bus.freeze_o) pc_reg <= bus.pc_next_o;
    assign bus.pc_cur = loop_en ? pc_reg : pc_drv;

    int errors = 0;
    int checks = 0;

    // Reference model: behavioural flags rather than a state register.
    bit          m_boot, m_halted, m_stalled;
    logic [15:0] m_pc;
    int          m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1; m_halted = 1'b0; m_stalled = 1'b0; m_pc = ResetVec; m_cnt = 0;
    endtask

    task automatic cycle(input bit rdy, input bit h, input bit br, input logic [15:0] tgt);
        logic [15:0] e_next;
        bit e_frz, e_req;
        logic [1:0] e_state;
        bit n_boot, n_halted, n_stalled;
        int n_cnt;
        bus.imem_ready_i = rdy; bus.halt_i = h; bus.br_taken_i = br; bus.br_target_i = tgt;
        @(negedge clk);
        n_boot = 1'b0; n_halted = m_halted; n_stalled = m_stalled; n_cnt = m_cnt;
        if (m_boot) begin
            e_state = 2'b00; e_req = 1'b0; e_frz = 1'b0; e_next = ResetVec;
            n_stalled = 1'b0;
        end else if (m_halted) begin
            e_state = 2'b11; e_req = 1'b0; e_frz = 1'b1; e_next = m_pc;
        end else begin
            e_state = m_stalled ? 2'b10 : 2'b01;
            e_req = 1'b1;
            if (!rdy) begin
                e_frz = 1'b1; e_next = m_pc; n_stalled = 1'b1;
            end else if (h) begin
                e_frz = 1'b1; e_next = m_pc; n_halted = 1'b1;
            end else begin
                e_frz = 1'b0; n_stalled = 1'b0;
                e_next = br ? (tgt & 16'hFFFE) : 16'((32'(m_pc) + 2) % 65536);
                n_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            end
        end
        check("pc_cur", {16'h0, pc_reg}, {16'h0, m_pc});
        check("state_o", {30'h0, bus.state_o}, {30'h0, e_state});
        check("freeze_o", {31'h0, bus.freeze_o}, {31'h0, e_frz});
        check("imem_req_o", {31'h0, bus.imem_req_o}, {31'h0, e_req});
        check("pc_next_o", {16'h0, bus.pc_next_o}, {16'h0, e_next});
        check("halted_o", {31'h0, bus.halted_o}, {31'h0, m_halted});
`ifdef PC_FETCH_INSTR_COUNT_EN
        check("instr_count_o", {16'h0, bus.instr_count_o}, m_cnt);
`endif
        @(posedge clk);
        #1;
        m_boot = n_boot; m_halted = n_halted; m_stalled = n_stalled; m_cnt = n_cnt;
        if (!e_frz) m_pc = e_next;
    endtask

    // Asynchronous reset mid-cycle; outputs must react without a clock edge.
    task automatic do_reset(input int n);
        #1 rst = 1'b0;
        #1;
        check("rst_state", {30'h0, bus.state_o}, 32'h0);
        check("rst_freeze", {31'h0, bus.freeze_o}, 32'h0);
        check("rst_req", {31'h0, bus.imem_req_o}, 32'h0);
        check("rst_halted", {31'h0, bus.halted_o}, 32'h0);
        check("rst_pc_next", {16'h0, bus.pc_next_o}, {16'h0, ResetVec});
        model_reset();
        repeat (n) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    typedef struct {
        logic [15:0] pc;
        bit          rdy, h, br;
        logic [15:0] tgt;
        logic [15:0] nxt;
        bit          frz;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{16'h0010, 1'b1, 1'b0, 1'b1, 16'h0101, 16'h0100, 1'b0};
        vecs[1] = '{16'h0010, 1'b1, 1'b1, 1'b1, 16'h0101, 16'h0010, 1'b1};
        vecs[2] = '{16'hFFFE, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[3] = '{16'h1234, 1'b0, 1'b1, 1'b1, 16'h5555, 16'h1234, 1'b1};
        vecs[4] = '{16'h1234, 1'b1, 1'b0, 1'b0, 16'h5555, 16'h1236, 1'b0};
        vecs[5] = '{16'h0004, 1'b1, 1'b0, 1'b1, 16'hFFFF, 16'hFFFE, 1'b0};
        vecs[6] = '{16'h7FFF, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h8001, 1'b0};
        vecs[7] = '{16'hABCD, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hABCD, 1'b1};

        bus.imem_ready_i = 1'b0; bus.halt_i = 1'b0; bus.br_taken_i = 1'b0;
        bus.br_target_i = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("init_state", {30'h0, bus.state_o}, 32'h0);
        check("init_halted", {31'h0, bus.halted_o}, 32'h0);
        model_reset();
        rst = 1'b1;

        // Reset release with ready every cycle: 0000, 0002, 0004, 0006.
        cycle(1'b0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            check("seq_pc", {16'h0, pc_reg}, 32'(i * 2));
            cycle(1'b1, 1'b0, 1'b0, 16'h0);
        end

        // Combinational vectors from FETCH/WAIT with pc_cur driven directly.
        loop_en = 1'b0;
        foreach (vecs[i]) begin
            pc_drv = vecs[i].pc;
            bus.imem_ready_i = vecs[i].rdy; bus.halt_i = vecs[i].h;
            bus.br_taken_i = vecs[i].br; bus.br_target_i = vecs[i].tgt;
            #1;
            check("vec_pc_next", {16'h0, bus.pc_next_o}, {16'h0, vecs[i].nxt});
            check("vec_freeze", {31'h0, bus.freeze_o}, {31'h0, vecs[i].frz});
            check("vec_req", {31'h0, bus.imem_req_o}, 32'h1);
            bus.imem_ready_i = 1'b0; bus.halt_i = 1'b0; bus.br_taken_i = 1'b0;
            @(posedge clk);
            #1;
        end
        loop_en = 1'b1;
        do_reset(1);

        // Stall three cycles at 0004, then resume to 0006.
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        repeat (3) cycle(1'b0, 1'b1, 1'b1, 16'h3333);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        check("stall_resume_pc", {16'h0, pc_reg}, 32'h0006);

        // Branch to 0010, odd target 0101 lands on 0100, back to 0010, then halt.
        cycle(1'b1, 1'b0, 1'b1, 16'h0010);
        cycle(1'b1, 1'b0, 1'b1, 16'h0101);
        check("br_pc", {16'h0, pc_reg}, 32'h0100);
        cycle(1'b1, 1'b0, 1'b1, 16'h0010);
        cycle(1'b1, 1'b1, 1'b1, 16'h0101);
        check("halt_pc", {16'h0, pc_reg}, 32'h0010);
        check("halt_flag", {31'h0, bus.halted_o}, 32'h1);
        repeat (3) cycle(1'b1, 1'b0, 1'b1, 16'h0200);
        do_reset(2);

        // Wrap at FFFE, then reset during WAIT.
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 1'b1, 16'hFFFE);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        check("wrap_pc", {16'h0, pc_reg}, 32'h0000);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);
        do_reset(1);

        // Five accepts, one stall, then HLT.
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b1, 1'b0, 16'h0);
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 16'h0);
`ifdef PC_FETCH_INSTR_COUNT_EN
        check("count_halt", {16'h0, bus.instr_count_o}, 32'd5);
`endif
        do_reset(1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if (m_halted && ($urandom_range(0, 3) == 0)) begin
                do_reset($urandom_range(1, 2));
            end else begin
                cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0),
                      ($urandom_range(0, 3) == 0), 16'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
